lcd_bus_receiver: RTL and testbench

Passive responder for the HD44780 16x2 character-LCD bus: samples the EN/RS/RW/DATA lines driven by the LCD controller and rebuilds the visible 2x16 display contents as two parallel character lines. It sits beside the LCD controller output pins as a mirror, so the GSM/FPGA design can forward displayed text (e.g. over UART) and the bench can check LCD traffic without a physical display. Write-only semantics; read cycles are observed but do not alter state.

---
 rtl/lcd_rx_pkg.sv | 40 ++++
 rtl/lcd_rx_sync.sv | 66 ++++++
 rtl/lcd_bus_receiver.sv | 180 ++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rx_pkg.sv
// Shared constants, FSM state type and DDRAM address stepping for the
// HD44780 bus mirror (lcd_bus_receiver).
package lcd_rx_pkg;

  localparam int unsigned NUM_CELLS  = 32;
  localparam logic [7:0]  CHAR_SPACE = 8'h20;
  localparam logic [6:0]  LINE2_BASE = 7'h40;
  localparam logic [6:0]  LINE1_END  = 7'h27;
  localparam logic [6:0]  LINE2_END  = 7'h67;

  // Command opcodes are identified by their highest set bit.
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR
  } state_t;

  // Next DDRAM address, jumping between the two 40-byte line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE1_END)      r = LINE2_BASE;
      else if (ac == LINE2_END) r = 7'h00;
      else                      r = ac + 7'd1;
    end else begin
      if (ac == 7'h00)           r = LINE2_END;
      else if (ac == LINE2_BASE) r = LINE1_END;
      else                       r = ac - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_rx_sync.sv
// Synchronizes the LCD bus pins, measures EN-high width and flags the
// EN falling edge as either an accepted strobe or a too-short pulse.
module lcd_rx_sync #(
  parameter int unsigned MIN_EN_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic       strobe_c,
  output logic       short_c,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);

  localparam int unsigned CW = $clog2(MIN_EN_HIGH + 1);

  logic [1:0]    en_ff;
  logic [1:0]    rs_ff;
  logic [1:0]    rw_ff;
  logic [7:0]    data_ff1;
  logic [7:0]    data_ff2;
  logic          en_d;
  logic [CW-1:0] width;
  logic          fall_c;

  // Two-flop synchronizers, saturating width counter and capture of the
  // bus lines while EN is high (so the value before the fall is held).
  always_ff @(posedge clk) begin
    if (rst) begin
      en_ff    <= '0;
      rs_ff    <= '0;
      rw_ff    <= '0;
      data_ff1 <= '0;
      data_ff2 <= '0;
      en_d     <= 1'b0;
      width    <= '0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= '0;
    end else begin
      en_ff    <= {en_ff[0], en};
      rs_ff    <= {rs_ff[0], rs};
      rw_ff    <= {rw_ff[0], rw};
      data_ff1 <= data;
      data_ff2 <= data_ff1;
      en_d     <= en_ff[1];
      if (en_ff[1]) begin
        if (width != CW'(MIN_EN_HIGH)) width <= width + CW'(1);
        cap_rs   <= rs_ff[1];
        cap_rw   <= rw_ff[1];
        cap_data <= data_ff2;
      end else begin
        width <= '0;
      end
    end
  end

  assign fall_c   = en_d & ~en_ff[1];
  assign strobe_c = fall_c & (width >= CW'(MIN_EN_HIGH));
  assign short_c  = fall_c & (width <  CW'(MIN_EN_HIGH));

endmodule

// File: rtl/lcd_bus_receiver.sv
// Passive HD44780 bus mirror: rebuilds the 2x16 visible DDRAM contents from
// observed write strobes. Optional violation counter: LCD_BUS_RECEIVER_VIOL_EN.
module lcd_bus_receiver
  import lcd_rx_pkg::*;
#(
  parameter int unsigned MIN_EN_HIGH = 4
) (
  input  logic         iCLK_50MHZ,
  input  logic         iRST,
  input  logic         LCD_EN,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [7:0]   LCD_DATA,
  output logic [127:0] oLINE1,
  output logic [127:0] oLINE2,
  output logic         oDISP_ON,
  output logic         oBUSY,
  output logic         oUPDATE,
  output logic         oCMD_VALID,
  output logic [8:0]   oCMD,
  output logic [7:0]   oVIOL_CNT
);

  logic                      strobe_c, short_c, cap_rs, cap_rw;
  logic [7:0]                cap_data;
  logic                      accept_c, drop_c;
  state_t                    state, state_n;
  logic [6:0]                ac, ac_n;
  logic                      id, id_n, cg, cg_n;
  logic                      disp_n, busy_n, upd_n, valid_n;
  logic [8:0]                cmd_n;
  logic [4:0]                clr_idx, clr_n;
  logic                      wr_en;
  logic [4:0]                wr_idx;
  logic [7:0]                wr_chr;
  logic [7:0]                cmd_byte;
  logic [NUM_CELLS-1:0][7:0] cells;

  lcd_rx_sync #(.MIN_EN_HIGH(MIN_EN_HIGH)) u_sync (
    .clk      (iCLK_50MHZ),
    .rst      (iRST),
    .en       (LCD_EN),
    .rs       (LCD_RS),
    .rw       (LCD_RW),
    .data     (LCD_DATA),
    .strobe_c (strobe_c),
    .short_c  (short_c),
    .cap_rs   (cap_rs),
    .cap_rw   (cap_rw),
    .cap_data (cap_data)
  );

  assign accept_c = strobe_c & ~cap_rw;
  assign cmd_byte = oCMD[7:0];

  // Next-state, command execution and clear sequencing.
  always_comb begin
    state_n = state;
    ac_n    = ac;
    id_n    = id;
    cg_n    = cg;
    disp_n  = oDISP_ON;
    busy_n  = oBUSY;
    upd_n   = 1'b0;
    valid_n = 1'b0;
    cmd_n   = oCMD;
    clr_n   = clr_idx;
    wr_en   = 1'b0;
    wr_idx  = 5'd0;
    wr_chr  = CHAR_SPACE;
    drop_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          valid_n = 1'b1;
          cmd_n   = {cap_rs, cap_data};
          if (!cap_rs && cap_data == OP_CLEAR) begin
            state_n = ST_CLEAR;
            busy_n  = 1'b1;
            clr_n   = 5'd0;
          end else begin
            state_n = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_n = ST_IDLE;
        if (oCMD[8]) begin
          if (!cg) begin
            if (ac[5:4] == 2'b00) begin
              wr_en  = 1'b1;
              wr_idx = {ac[6], ac[3:0]};
              wr_chr = cmd_byte;
              upd_n  = 1'b1;
            end
            ac_n = ac_step(ac, id);
          end
        end else if (|(cmd_byte & OP_DDRAM)) begin
          ac_n = cmd_byte[6:0];
          cg_n = 1'b0;
        end else if (|(cmd_byte & OP_CGRAM)) begin
          cg_n = 1'b1;
        end else if (cmd_byte[7:4] == 4'h0) begin
          if (|(cmd_byte & OP_DISP))       disp_n = cmd_byte[2];
          else if (|(cmd_byte & OP_ENTRY)) id_n   = cmd_byte[1];
          else if (|(cmd_byte & OP_HOME))  ac_n   = 7'h00;
        end
      end
      ST_CLEAR: begin
        drop_c = accept_c;
        wr_en  = 1'b1;
        wr_idx = clr_idx;
        clr_n  = clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          upd_n   = 1'b1;
          ac_n    = 7'h00;
          id_n    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge iCLK_50MHZ) begin
    if (iRST) begin
      state      <= ST_IDLE;
      ac         <= 7'h00;
      id         <= 1'b1;
      cg         <= 1'b0;
      clr_idx    <= 5'd0;
      oDISP_ON   <= 1'b0;
      oBUSY      <= 1'b0;
      oUPDATE    <= 1'b0;
      oCMD_VALID <= 1'b0;
      oCMD       <= 9'h000;
    end else begin
      state      <= state_n;
      ac         <= ac_n;
      id         <= id_n;
      cg         <= cg_n;
      clr_idx    <= clr_n;
      oDISP_ON   <= disp_n;
      oBUSY      <= busy_n;
      oUPDATE    <= upd_n;
      oCMD_VALID <= valid_n;
      oCMD       <= cmd_n;
    end
  end

  // Character buffer; reset also aborts an in-progress clear.
  always_ff @(posedge iCLK_50MHZ) begin
    if (iRST)       cells <= {NUM_CELLS{CHAR_SPACE}};
    else if (wr_en) cells[wr_idx] <= wr_chr;
  end

  for (genvar c = 0; c < 16; c++) begin : g_col
    assign oLINE1[127-8*c -: 8] = cells[c];
    assign oLINE2[127-8*c -: 8] = cells[16+c];
  end

`ifdef LCD_BUS_RECEIVER_VIOL_EN
  logic [7:0] viol_cnt;

  // Saturating count of short EN pulses and strobes dropped during a clear.
  always_ff @(posedge iCLK_50MHZ) begin
    if (iRST)                                      viol_cnt <= 8'h00;
    else if ((short_c | drop_c) && viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
  end

  assign oVIOL_CNT = viol_cnt;
`else
  logic unused_viol;
  assign unused_viol = short_c | drop_c;
  assign oVIOL_CNT   = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed scenarios plus random
// command/data traffic compared against a behavioural display model.
module tb_lcd_bus_receiver;

  localparam int MIN = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, rs_pin, rw_pin;
  logic [7:0]   data_pin;
  logic [127:0] line1, line2;
  logic         disp_on, busy, update, cmd_valid;
  logic [8:0]   cmd;
  logic [7:0]   viol_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the visible display.
  logic [7:0] mbuf [32];
  int mac, mid, mcg, mdisp, mviol;

  // Monitor state.
  int         upd_cnt  = 0;
  int         cur_run  = 0;
  int         last_run = 0;
  logic       prev_busy = 1'b0;
  logic       fall_upd  = 1'b0;
  logic       busy_at_valid = 1'b0;
  logic [8:0] cmd_seen = 9'h000;

  always #5 clk = ~clk;

  lcd_bus_receiver #(.MIN_EN_HIGH(MIN)) dut (
    .iCLK_50MHZ (clk),
    .iRST       (rst),
    .LCD_EN     (en),
    .LCD_RS     (rs_pin),
    .LCD_RW     (rw_pin),
    .LCD_DATA   (data_pin),
    .oLINE1     (line1),
    .oLINE2     (line2),
    .oDISP_ON   (disp_on),
    .oBUSY      (busy),
    .oUPDATE    (update),
    .oCMD_VALID (cmd_valid),
    .oCMD       (cmd),
    .oVIOL_CNT  (viol_cnt)
  );

  always @(negedge clk) begin
    if (update) upd_cnt++;
    if (busy) cur_run++;
    else if (prev_busy) begin
      last_run = cur_run;
      cur_run  = 0;
      fall_upd = update;
    end
    prev_busy = busy;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mline(input int row);
    logic [127:0] l;
    for (int c = 0; c < 16; c++) l[127-8*c -: 8] = mbuf[row*16+c];
    return l;
  endfunction

  function automatic logic [127:0] exp_viol();
`ifdef LCD_BUS_RECEIVER_VIOL_EN
    return 128'(mviol);
`else
    return 128'(0);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    mac = 0;
    mid = 1;
  endtask

  task automatic model_reset();
    model_clear();
    mcg = 0; mdisp = 0; mviol = 0;
  endtask

  task automatic model_step();
    if (mid != 0) mac = (mac == 39) ? 64 : (mac == 103) ? 0 : (mac + 1) % 128;
    else          mac = (mac == 0) ? 103 : (mac == 64) ? 39 : mac - 1;
  endtask

  // Applies an accepted write; returns 1 if a visible cell changed.
  task automatic model_apply(input int is_data, input int d, output int vis);
    vis = 0;
    if (is_data != 0) begin
      if (mcg == 0) begin
        if ((mac % 64) < 16) begin
          mbuf[(mac / 64) * 16 + (mac % 64)] = 8'(d);
          vis = 1;
        end
        model_step();
      end
    end else if (d >= 128) begin mac = d - 128; mcg = 0; end
    else if (d >= 64) mcg = 1;
    else if (d >= 16) vis = 0;
    else if (d >= 8)  mdisp = (d >> 2) & 1;
    else if (d >= 4)  mid = (d >> 1) & 1;
    else if (d >= 2)  mac = 0;
    else if (d == 1)  model_clear();
  endtask

  // Drives one EN pulse of w cycles and checks the receiver's reaction.
  task automatic do_op(input logic rs, input logic rw, input logic [7:0] d,
                       input int w, input bit drop);
    int lat, u0, vis;
    bit acc, is_clr;
    u0 = upd_cnt;
    @(posedge clk); #1;
    rs_pin = rs; rw_pin = rw; data_pin = d; en = 1'b1;
    repeat (w) @(posedge clk);
    #1 en = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (cmd_valid && lat == 0) begin
        lat = i;
        cmd_seen = cmd;
        busy_at_valid = busy;
      end
    end
    #1;
    acc    = !rw && (w >= MIN) && !drop;
    is_clr = !rs && (d == 8'h01);
    check("strobe_latency", 128'(lat), 128'(acc ? 3 : 0));
    vis = 0;
    if (acc) begin
      check("cmd_word", 128'(cmd_seen), 128'({rs, d}));
      model_apply(int'(rs), int'(d), vis);
    end
    if (w < MIN || (drop && !rw)) mviol = (mviol < 255) ? mviol + 1 : 255;
    if (!drop && !is_clr) begin
      check("line1", line1, mline(0));
      check("line2", line2, mline(1));
      check("disp_on", 128'(disp_on), 128'(mdisp));
      check("update_count", 128'(upd_cnt - u0), 128'(vis));
    end
    check("viol_cnt", 128'(viol_cnt), exp_viol());
  endtask

  initial begin
    logic [39:0] hello;
    logic [15:0] ab;
    logic [7:0]  d;
    int u0, k, w, a, r;
    logic rs, rw;

    hello = "HELLO";
    ab    = "AB";
    rst = 1'b1; en = 1'b0; rs_pin = 1'b0; rw_pin = 1'b0; data_pin = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_line1", line1, mline(0));
    check("rst_line2", line2, mline(1));
    check("rst_disp", 128'(disp_on), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_update", 128'(update), 128'(0));
    check("rst_valid", 128'(cmd_valid), 128'(0));
    check("rst_cmd", 128'(cmd), 128'(0));
    check("rst_viol", 128'(viol_cnt), 128'(0));

    // Init sequence and "HELLO" on row 0.
    u0 = upd_cnt;
    do_op(0, 0, 8'h38, 6, 0);
    do_op(0, 0, 8'h0C, 6, 0);
    do_op(0, 0, 8'h06, 6, 0);
    do_op(0, 0, 8'h80, 6, 0);
    for (int i = 0; i < 5; i++) do_op(1, 0, hello[39-8*i -: 8], 6, 0);
    check("hello_updates", 128'(upd_cnt - u0), 128'(5));
    check("hello_text", 128'(line1[127:88]), 128'(hello));
    check("hello_disp", 128'(disp_on), 128'(1));

    // Row 1 addressing.
    do_op(0, 0, 8'hC0, 5, 0);
    do_op(1, 0, ab[15:8], 5, 0);
    do_op(1, 0, ab[7:0], 5, 0);
    check("ab_text", 128'(line2[127:112]), 128'(ab));

    // Column 15 then off-screen 0x10.
    do_op(0, 0, 8'h8F, 5, 0);
    do_op(1, 0, 8'h58, 5, 0);
    do_op(1, 0, 8'h59, 5, 0);
    check("x_at_col15", 128'(line1[7:0]), 128'(8'h58));

    // Wrap 0x27 -> 0x40.
    do_op(0, 0, 8'hA7, 5, 0);
    do_op(1, 0, 8'h4D, 5, 0);
    do_op(1, 0, 8'h4E, 5, 0);
    check("wrap_row1_col0", 128'(line2[127:120]), 128'(8'h4E));

    // Short pulses and the exact minimum width.
    do_op(1, 0, 8'h51, 2, 0);
    do_op(1, 0, 8'h52, MIN - 1, 0);
    do_op(0, 0, 8'h80, MIN, 0);
    do_op(1, 0, 8'h4B, MIN, 0);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      k  = int'($urandom_range(0, 11));
      w  = int'($urandom_range(MIN, MIN + 3));
      rs = 1'b0; rw = 1'b0;
      case (k)
        0, 1: begin
          r = int'($urandom_range(0, 3));
          if (r == 0)      a = int'($urandom_range(0, 15));
          else if (r == 1) a = 64 + int'($urandom_range(0, 15));
          else if (r == 2) a = (($urandom_range(0, 1) == 0) ? 32 : 96) + int'($urandom_range(0, 7));
          else             a = int'($urandom_range(0, 127));
          d = 8'(128 + a);
        end
        2: d = 8'(4 + $urandom_range(0, 3));
        3: d = 8'(8 + $urandom_range(0, 7));
        4: d = 8'(2 + $urandom_range(0, 1));
        5: d = 8'($urandom_range(16, 63));
        6: d = 8'(64 + $urandom_range(0, 63));
        10: begin rw = 1'b1; rs = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255)); end
        default: begin rs = 1'b1; d = 8'($urandom_range(33, 126)); end
      endcase
      do_op(rs, rw, d, w, 0);
    end

    // Clear with a write landing inside it; clear must also restore AC and ID.
    do_op(0, 0, 8'h85, 5, 0);
    do_op(0, 0, 8'h04, 5, 0);
    u0 = upd_cnt;
    do_op(0, 0, 8'h01, 6, 0);
    check("busy_with_valid", 128'(busy_at_valid), 128'(1));
    do_op(1, 0, 8'h5A, 6, 1);
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    check("clear_busy_done", 128'(busy), 128'(0));
    check("clear_busy_len", 128'(last_run), 128'(32));
    check("clear_upd_at_fall", 128'(fall_upd), 128'(1));
    check("clear_updates", 128'(upd_cnt - u0), 128'(1));
    check("clear_line1", line1, mline(0));
    check("clear_line2", line2, mline(1));
    check("clear_viol", 128'(viol_cnt), exp_viol());
    do_op(1, 0, 8'h50, 5, 0);
    do_op(1, 0, 8'h51, 5, 0);

    // Reset in the middle of a clear.
    do_op(0, 0, 8'hCF, 5, 0);
    do_op(1, 0, 8'h57, 5, 0);
    do_op(0, 0, 8'h01, 6, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    u0 = upd_cnt;
    @(negedge clk); #1;
    check("abort_line1", line1, mline(0));
    check("abort_line2", line2, mline(1));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_viol", 128'(viol_cnt), exp_viol());
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    check("abort_no_update", 128'(upd_cnt - u0), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
